sbox_combi: RTL and testbench
=============================

SBOX_COMBI -- requirements
Module: sbox_combi

Interface
REQ-001 Parameter: OUT_REG, default 1, meaning 1 = registered copy sbox_out_q is driven, 0 = sbox_out_q tied to 8'h00.
REQ-002 clk  input  1  single clock; only the registered copy uses it.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en_or_de  input  1  mode: 1 = forward S-box (encrypt), 0 = inverse S-box (decrypt).
REQ-005 sbox_in  input  8  byte to substitute.
REQ-006 sbox_out  output  8  substituted byte, purely combinational from en_or_de and sbox_in.
REQ-007 sbox_out_q  output  8  sbox_out registered on the rising edge of clk.

Function
REQ-008 Field: GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
REQ-009 Multiplicative inverse inv(a) is computed by logic, with inv(0x00) = 0x00; no 256-entry ROM or case table.
REQ-010 Forward affine, bit i (indices mod 8): b_i = a_i ^ a_(i+4) ^ a_(i+5) ^ a_(i+6) ^ a_(i+7) ^ c_i, with c = 0x63.
REQ-011 Inverse affine, bit i: b_i = a_(i+2) ^ a_(i+5) ^ a_(i+7) ^ d_i, with d = 0x05.
REQ-012 en_or_de=1: sbox_out = Affine(inv(sbox_in)).
REQ-013 en_or_de=0: sbox_out = inv(InvAffine(sbox_in)).
REQ-014 For every byte x, inverse(forward(x)) = x.
REQ-015 sbox_out has zero-cycle latency and no internal state.
REQ-016 sbox_out settles within one clock period of any input change.
REQ-017 Changing en_or_de changes sbox_out combinationally, with no glitch-hold requirement.
REQ-018 With OUT_REG=1, sbox_out_q samples sbox_out on every rising clk edge (1-cycle latency, no enable).
REQ-019 If en_or_de toggles in the same cycle as sbox_in, the output reflects both new values.
REQ-020 Inputs that are X or Z are not required to produce a defined output.

Reset
REQ-021 rst high at a rising clk edge sets sbox_out_q to 8'h00.
REQ-022 rst does not affect sbox_out; the combinational path stays valid during reset.
REQ-023 Reset asserted mid-stream clears sbox_out_q on that edge only.
REQ-024 On the first edge after rst deasserts, sbox_out_q returns to tracking sbox_out.

Structure
REQ-025 A shared package aes_pkg holds:
- constants AFFINE_C = 8'h63, INV_AFFINE_D = 8'h05, GF_POLY = 9'h11B;
- functions gf_mul and the forward/inverse affine transforms.
REQ-026 One sub-module, gf256_inv (8-bit combinational inverter), is natural.
REQ-027 gf256_inv may use a composite-field GF((2^4)^2) decomposition with isomorphism and inverse-isomorphism mappings.
REQ-028 sbox_combi contains two muxes around gf256_inv:
- pre-inverse mux: selects sbox_in or InvAffine(sbox_in);
- post-inverse mux: selects Affine(inv) or inv.
REQ-029 sbox_combi contains the optional output register.

Verification
REQ-030 en_or_de=1, sbox_in 00,01,02,03,04,05,06,07 -> sbox_out 63,7c,77,7b,f2,6b,6f,c5.
REQ-031 en_or_de=1, sbox_in 08,09,0a,0b,0c,0d,0e,0f -> sbox_out 30,01,67,2b,fe,d7,ab,76.
REQ-032 en_or_de=1, sbox_in 10,20,30,40,53 -> sbox_out ca,b7,04,09,ed.
REQ-033 en_or_de=0, sbox_in 63,7c,00,ed,09 -> sbox_out 00,01,52,53,40.
REQ-034 Exhaustive check over all 256 x:
- inverse(forward(x)) = x;
- forward output is a permutation with no fixed point;
- all checked 5 ns after input change.
REQ-035 Register and reset sequence, OUT_REG=1:
- rst=1 for 2 clk edges -> sbox_out_q=00;
- release rst, apply sbox_in=01, en_or_de=1 -> sbox_out_q=7c after the next edge;
- assert rst mid-stream -> sbox_out_q=00 on that edge while sbox_out stays 7c.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared GF(2^8) constants, multiplier and AES affine transforms
package aes_pkg;
  localparam logic [7:0] AFFINE_C     = 8'h63;
  localparam logic [7:0] INV_AFFINE_D = 8'h05;
  localparam logic [8:0] GF_POLY      = 9'h11B;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
    end
    return p;
  endfunction
  function automatic logic [7:0] affine(input logic [7:0] a);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++)
      b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8] ^ a[(i + 7) % 8] ^ AFFINE_C[i];
    return b;
  endfunction
  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++)
      b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8] ^ INV_AFFINE_D[i];
    return b;
  endfunction
endpackage

// File: rtl/gf256_inv.sv
// gf256_inv: combinational GF(2^8) inverse as a^254, with 0 mapping to 0
module gf256_inv
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] a_inv
);
  logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
  // addition chain for a^254 = a^-1; zero input naturally yields zero
  always_comb begin
    a2    = gf_mul(a, a);
    a3    = gf_mul(a2, a);
    a6    = gf_mul(a3, a3);
    a12   = gf_mul(a6, a6);
    a15   = gf_mul(a12, a3);
    a30   = gf_mul(a15, a15);
    a60   = gf_mul(a30, a30);
    a120  = gf_mul(a60, a60);
    a240  = gf_mul(a120, a120);
    a252  = gf_mul(a240, a12);
    a_inv = gf_mul(a252, a2);
  end
endmodule

// File: rtl/sbox_combi.sv
// sbox_combi: AES forward/inverse S-box with optional registered copy
module sbox_combi
  import aes_pkg::*;
#(
  parameter bit OUT_REG = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_or_de,
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out,
  output logic [7:0] sbox_out_q
);
  logic [7:0] pre_inv, post_inv;
  // pre-inverse mux: decrypt undoes the affine step before inversion
  always_comb pre_inv = en_or_de ? sbox_in : inv_affine(sbox_in);
  gf256_inv u_inv (.a(pre_inv), .a_inv(post_inv));
  // post-inverse mux: encrypt applies the affine step after inversion
  always_comb sbox_out = en_or_de ? affine(post_inv) : post_inv;
  if (OUT_REG) begin : g_reg
    logic [7:0] out_d, out_q;
    // registered copy simply follows the combinational result
    always_comb out_d = sbox_out;
    // output register with synchronous clear
    always_ff @(posedge clk)
      if (rst) out_q <= '0;
      else out_q <= out_d;
    assign sbox_out_q = out_q;
  end else begin : g_noreg
    assign sbox_out_q = '0;
  end
endmodule

// File: tb/tb_sbox_combi.sv
// tb_sbox_combi: scoreboard bench against a table-built S-box reference model
module tb_sbox_combi;
  logic       clk = 0;
  logic       rst = 1;
  logic       en_or_de = 1;
  logic [7:0] sbox_in = '0;
  logic [7:0] sbox_out, sbox_out_q;
  int compared = 0;
  int mismatched = 0;
  typedef struct {
    logic [7:0] in;
    logic       mode;
    logic [7:0] comb_exp;
    logic [7:0] reg_exp;
    bit         sweep;
  } item_t;
  item_t exp_q[$];
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];
  bit seen [256];
  int fixed_pts = 0;
  sbox_combi #(.OUT_REG(1)) dut (
    .clk(clk), .rst(rst), .en_or_de(en_or_de),
    .sbox_in(sbox_in), .sbox_out(sbox_out), .sbox_out_q(sbox_out_q)
  );
  always #6 clk = ~clk;
  function automatic logic [7:0] ref_mul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) if ((b >> i) & 1) p ^= a << i;
    for (int k = 14; k >= 8; k--) if ((p >> k) & 1) p ^= 'h11B << (k - 8);
    return p[7:0];
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction
  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv = 0;
      for (int y = 1; y < 256; y++) if (ref_mul(x, y) == 8'h01) iv = y[7:0];
      fwd_tab[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = x[7:0];
  end
  task automatic drive(input logic m, input logic [7:0] v, input logic r, input logic [7:0] e, input bit sw);
    item_t it;
    @(posedge clk);
    #1;
    en_or_de = m;
    sbox_in = v;
    rst = r;
    it.in = v; it.mode = m; it.comb_exp = e; it.reg_exp = r ? 8'h00 : e; it.sweep = sw;
    exp_q.push_back(it);
  endtask
  function automatic logic [7:0] model(input logic m, input logic [7:0] v);
    return m ? fwd_tab[v] : inv_tab[v];
  endfunction
  logic [7:0] pend;
  bit pend_valid = 0;
  // monitor: sample mid-cycle, check registered result of previous item then this item's comb output
  always @(negedge clk) begin
    item_t it;
    if (pend_valid) begin
      compared++;
      if (sbox_out_q !== pend) begin
        mismatched++;
        $display("FAIL reg sbox_out_q got=%h exp=%h", sbox_out_q, pend);
      end
    end
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      compared++;
      if (sbox_out !== it.comb_exp) begin
        mismatched++;
        $display("FAIL comb in=%h mode=%b got=%h exp=%h", it.in, it.mode, sbox_out, it.comb_exp);
      end
      if (it.sweep) begin
        seen[sbox_out] = 1;
        if (sbox_out == it.in) fixed_pts++;
      end
      pend = it.reg_exp;
      pend_valid = 1;
    end else pend_valid = 0;
  end
  logic [7:0] d_in [29] = '{8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09,8'h0a,8'h0b,8'h0c,8'h0d,8'h0e,8'h0f,
                            8'h10,8'h20,8'h30,8'h40,8'h53, 8'h63,8'h7c,8'h00,8'hed,8'h09, 8'h00,8'h00,8'h00};
  logic [7:0] d_out [29] = '{8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
                             8'hca,8'hb7,8'h04,8'h09,8'hed, 8'h00,8'h01,8'h52,8'h53,8'h40, 8'h00,8'h00,8'h00};
  initial begin
    int distinct;
    #1;
    drive(1, 8'h01, 1, 8'h7c, 0);
    drive(1, 8'h01, 1, 8'h7c, 0);
    drive(1, 8'h01, 0, 8'h7c, 0);
    drive(1, 8'h01, 0, 8'h7c, 0);
    drive(1, 8'h01, 1, 8'h7c, 0);
    drive(1, 8'h01, 0, 8'h7c, 0);
    for (int i = 0; i < 26; i++) drive(i < 21, d_in[i], 0, d_out[i], 0);
    for (int x = 0; x < 256; x++) drive(1, x[7:0], 0, model(1, x[7:0]), 1);
    for (int x = 0; x < 256; x++) drive(0, fwd_tab[x], 0, x[7:0], 0);
    for (int i = 0; i < 300; i++) begin
      logic m = 1'($urandom);
      logic [7:0] v = 8'($urandom);
      drive(m, v, ($urandom_range(0, 15) == 0), model(m, v), 0);
    end
    repeat (3) @(negedge clk);
    #1;
    distinct = 0;
    for (int x = 0; x < 256; x++) distinct += int'(seen[x]);
    compared++;
    if (distinct != 256) begin
      mismatched++;
      $display("FAIL permutation distinct got=%0d exp=256", distinct);
    end
    compared++;
    if (fixed_pts != 0) begin
      mismatched++;
      $display("FAIL fixed_points got=%0d exp=0", fixed_pts);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
